// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator
//   Accumulates NIBBLES_PER_FRAME per-nibble ones counts (0..4 each) into a
//   frame total. The total is presented on a valid/ready output and held until
//   the consumer takes it. While the total is held, upstream is stalled.
//   Optional feature macro: ONES_ACC_THRESHOLD_EN adds the out_over flag
//   (frame total >= THRESHOLD). Without the macro the flag and its comparator
//   do not exist.

module ones_frame_accumulator #(
  parameter int NIBBLES_PER_FRAME = 8,
  parameter int SUM_W             = 6,
  parameter int THRESHOLD         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             cnt_err
`ifdef ONES_ACC_THRESHOLD_EN
  ,
  output logic             out_over
`endif
);

  // A one-entry frame still needs a 1-bit index so the register exists.
  localparam int IDX_W = (NIBBLES_PER_FRAME > 1) ? $clog2(NIBBLES_PER_FRAME) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES_PER_FRAME - 1);

  // Reject parameter sets where the frame total could wrap.
  if (NIBBLES_PER_FRAME < 1 || NIBBLES_PER_FRAME > 63) begin : g_bad_n
    $error("NIBBLES_PER_FRAME must be in 1..63");
  end
  if (SUM_W < 3 || (SUM_W < 31 && (1 << SUM_W) <= 4 * NIBBLES_PER_FRAME)) begin : g_bad_w
    $error("SUM_W too narrow: need 2**SUM_W > 4*NIBBLES_PER_FRAME");
  end
  if (THRESHOLD < 0) begin : g_bad_thr
    $error("THRESHOLD must be non-negative");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             err_q, err_d;

  logic             accept;
  logic             last_count;
  logic             count_illegal;
  logic [SUM_W-1:0] count_add;
  logic [SUM_W-1:0] frame_sum;

  // Transfer qualifier: in_ready is a pure state decode, so this never loops
  // back through in_valid.
  assign accept = in_valid && in_ready;

  // Count conditioning: illegal codes 5..7 saturate to the maximum legal 4.
  always_comb begin
    count_illegal = (in_count > 3'd4);
    count_add     = count_illegal ? SUM_W'(3'd4) : SUM_W'(in_count);
    frame_sum     = acc_q + count_add;
    last_count    = (idx_q == LAST_IDX);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <=, so every flop samples
    // the pre-edge value of every other flop regardless of block ordering.
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Next-state logic: the final accept of a frame enters HOLD; the output
  // handshake returns to ACCUM.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that skips
    // the assignment would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && last_count) state_d = HOLD;
      HOLD:    if (out_ready)            state_d = ACCUM;
      default:                           state_d = ACCUM;
    endcase
  end

  // Output decode: handshake flags come straight from the state register.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  // Datapath next-state: accumulate, step the index, capture the total on the
  // last count and restart the frame from zero. Idle cycles hold everything.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    sum_d = sum_q;
    err_d = err_q | (accept & count_illegal);
    if (accept) begin
      if (last_count) begin
        sum_d = frame_sum;
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = frame_sum;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Datapath registers; reset discards any partial frame and pending total.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign out_sum = sum_q;
  assign cnt_err = err_q;

`ifdef ONES_ACC_THRESHOLD_EN
  logic over_q, over_d;

  // Density flag is captured alongside the frame total so both share the same
  // validity window and hold behaviour.
  always_comb begin
    over_d = over_q;
    if (accept && last_count) over_d = (int'(frame_sum) >= THRESHOLD);
  end

  // Density flag register.
  always_ff @(posedge clk) begin
    if (rst) over_q <= 1'b0;
    else     over_q <= over_d;
  end

  assign out_over = over_q;
`endif

endmodule
